// File: rtl/conv_sequencer.sv
// conv_sequencer: walks a KERNEL_SIZE^2-lane multiply-accumulate accelerator through a job of
// operand windows. Defining CONV_SEQ_TIMEOUT_EN adds a watchdog that aborts a stuck WAIT.
module conv_sequencer #(
   parameter int unsigned KERNEL_SIZE    = 3,
   parameter int unsigned ADDR_WIDTH     = $clog2(KERNEL_SIZE**4),
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                                  Clk,
   input  logic                                  Rst_n,
   // Job command
   input  logic                                  cmd_valid,
   output logic                                  cmd_ready,
   input  logic [15:0]                           cmd_num_windows,
   input  logic [ADDR_WIDTH-1:0]                 cmd_addr,
   input  logic                                  cmd_direct,
   // Operand windows
   input  logic                                  win_valid,
   output logic                                  win_ready,
   input  logic [KERNEL_SIZE*KERNEL_SIZE*32-1:0] win_multiplier,
   input  logic [KERNEL_SIZE*KERNEL_SIZE*32-1:0] win_multiplicand,
   // Accelerator side
   output logic [KERNEL_SIZE*KERNEL_SIZE*32-1:0] acc_multiplier,
   output logic [KERNEL_SIZE*KERNEL_SIZE*32-1:0] acc_multiplicand,
   output logic [ADDR_WIDTH-1:0]                 acc_AddressSelect,
   output logic [KERNEL_SIZE*KERNEL_SIZE-1:0]    acc_mStart,
   output logic                                  acc_direct,
   input  logic [31:0]                           acc_finalAccumulate,
   input  logic                                  acc_finalReady,
   // Results and status
   output logic                                  res_valid,
   input  logic                                  res_ready,
   output logic [31:0]                           res_data,
   output logic                                  busy,
   output logic                                  done,
   output logic                                  error
);

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StStart,
      StWait,
      StOut
   } state_t;

   state_t      state;
   logic [15:0] num_windows;
   logic [15:0] win_count;

`ifdef CONV_SEQ_TIMEOUT_EN
   localparam int unsigned WdWidth = $clog2(TIMEOUT_CYCLES + 1);
   logic [WdWidth-1:0] wd_count;
   logic               error_q;
   assign error = error_q;
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
   assign error          = 1'b0;
`endif

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state             <= StIdle;
         num_windows       <= '0;
         win_count         <= '0;
         cmd_ready         <= 1'b0;
         win_ready         <= 1'b0;
         acc_multiplier    <= '0;
         acc_multiplicand  <= '0;
         acc_AddressSelect <= '0;
         acc_mStart        <= '0;
         acc_direct        <= 1'b0;
         res_valid         <= 1'b0;
         res_data          <= '0;
         busy              <= 1'b0;
         done              <= 1'b0;
`ifdef CONV_SEQ_TIMEOUT_EN
         wd_count          <= '0;
         error_q           <= 1'b0;
`endif
      end else begin
         done       <= 1'b0;
         acc_mStart <= '0;
         unique case (state)
            StIdle: begin
               cmd_ready <= 1'b1;
               if (cmd_valid && cmd_ready) begin
                  num_windows       <= cmd_num_windows;
                  acc_AddressSelect <= cmd_addr;
                  acc_direct        <= cmd_direct;
                  win_count         <= '0;
                  if (cmd_num_windows != 16'd0) begin
                     cmd_ready <= 1'b0;
                     win_ready <= 1'b1;
                     busy      <= 1'b1;
                     state     <= StLoad;
                  end else begin
                     // Empty job: completes immediately without leaving IDLE
                     done <= 1'b1;
                  end
               end
            end
            StLoad: begin
               if (win_valid) begin
                  acc_multiplier   <= win_multiplier;
                  acc_multiplicand <= win_multiplicand;
                  acc_mStart       <= '1;
                  win_ready        <= 1'b0;
                  state            <= StStart;
               end
            end
            StStart: begin
`ifdef CONV_SEQ_TIMEOUT_EN
               wd_count <= '0;
`endif
               state <= StWait;
            end
            StWait: begin
               if (acc_finalReady) begin
                  res_data  <= acc_finalAccumulate;
                  res_valid <= 1'b1;
                  state     <= StOut;
               end
`ifdef CONV_SEQ_TIMEOUT_EN
               else if (wd_count == WdWidth'(TIMEOUT_CYCLES - 1)) begin
                  // Accelerator never answered: abort the job, no result is produced
                  error_q   <= 1'b1;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= StIdle;
               end else begin
                  wd_count <= wd_count + 1'b1;
               end
`endif
            end
            StOut: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  win_count <= win_count + 16'd1;
                  if (win_count + 16'd1 == num_windows) begin
                     done      <= 1'b1;
                     busy      <= 1'b0;
                     cmd_ready <= 1'b1;
                     state     <= StIdle;
                  end else begin
                     win_ready <= 1'b1;
                     state     <= StLoad;
                  end
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: doc/conv_sequencer.md
CONV_SEQUENCER -- requirements
Module: conv_sequencer

Interface
REQ-001 SHALL have parameter KERNEL_SIZE, default 3, kernel edge length; accelerator has KERNEL_SIZE^2 lanes.
REQ-002 SHALL have parameter ADDR_WIDTH, default clog2(KERNEL_SIZE^4), crossbar address width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, watchdog limit (used only with CONV_SEQ_TIMEOUT_EN).
REQ-004 SHALL have ports: Clk  in  1  sole clock, rising edge; Rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: cmd_valid  in  1; cmd_ready  out  1; cmd_num_windows  in  16  windows in job; cmd_addr  in  ADDR_WIDTH  crossbar select; cmd_direct  in  1  crossbar direct mode.
REQ-006 SHALL have ports: win_valid  in  1; win_ready  out  1; win_multiplier, win_multiplicand  in  KERNEL_SIZE^2*32 each  one window of operands.
REQ-007 SHALL have ports: acc_multiplier, acc_multiplicand  out  KERNEL_SIZE^2*32; acc_AddressSelect  out  ADDR_WIDTH; acc_mStart  out  KERNEL_SIZE^2; acc_direct  out  1; acc_finalAccumulate  in  32; acc_finalReady  in  1.
REQ-008 SHALL have ports: res_valid  out  1; res_ready  in  1; res_data  out  32; busy  out  1; done  out  1  one-cycle job-complete pulse; error  out  1  sticky timeout flag.

Function
REQ-009 SHALL implement FSM states IDLE, LOAD, START, WAIT, OUT.
REQ-010 IDLE: cmd_ready=1; on cmd_valid, latch cmd_num_windows, cmd_addr, cmd_direct, clear window counter; go LOAD if count>0, else stay IDLE and pulse done next cycle.
REQ-011 LOAD: win_ready=1; on win_valid, register both operand buses into acc_multiplier/acc_multiplicand, go START.
REQ-012 START: drive acc_mStart all-ones for exactly one cycle, go WAIT; acc_mStart SHALL be zero in every other state.
REQ-013 WAIT: on acc_finalReady, capture acc_finalAccumulate into res_data, go OUT; acc_finalReady in any other state SHALL be ignored.
REQ-014 OUT: res_valid=1, res_data stable until res_ready; on res_valid&&res_ready increment window counter; if counter reaches latched count, pulse done and go IDLE, else go LOAD.
REQ-015 acc_AddressSelect and acc_direct SHALL equal the latched command values for the whole job and hold last values in IDLE.
REQ-016 busy SHALL be 1 in every state except IDLE.
REQ-017 Minimum per-window cycle count SHALL be LOAD 1 + START 1 + WAIT (accelerator latency) + OUT 1; res_valid asserts the cycle after acc_finalReady.
REQ-018 cmd_valid while busy SHALL be ignored (cmd_ready=0); win_valid outside LOAD SHALL not be consumed.
REQ-019 Window counter SHALL be 16-bit; cmd_num_windows=65535 SHALL complete without wrap.

Reset
REQ-020 Rst_n low SHALL asynchronously force IDLE and zero all outputs, counters and latched fields, including mid-job; cmd_ready SHALL be 1 from the first edge after release; error SHALL clear.

Configuration
REQ-021 Macro CONV_SEQ_TIMEOUT_EN defined: a counter runs in WAIT; reaching TIMEOUT_CYCLES without acc_finalReady SHALL set error, pulse done, abort to IDLE without res_valid; error cleared only by reset.
REQ-022 Macro undefined: no watchdog logic; WAIT holds indefinitely; error tied to 0.

Verification
REQ-023 Job count=1, addr=5, direct=0, window supplied, finalReady 4 cycles after mStart with value 0x0000_002D -> single one-cycle mStart=9'h1FF, res_data=0x2D, done one cycle after handshake.
REQ-024 Job count=3, res_ready low 5 cycles on second result -> res_data stable during stall, exactly 3 results, 3 mStart pulses, done once.
REQ-025 cmd_num_windows=0 -> no win_ready, no mStart, done pulse one cycle after command accept.
REQ-026 Rst_n low during WAIT of window 2 of 4 -> immediate IDLE, all outputs zero, later finalReady ignored, new command accepted after release.
REQ-027 CONV_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, finalReady never asserted -> error=1 and done pulse 16 cycles after entering WAIT, no res_valid; without macro, busy stays 1.
